// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Used by fetch_pc and fetch_ctrl.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD,
    HALTED
  } state_t;

  localparam logic [1:0] FETCH_IDLE = 2'b00;
  localparam logic [1:0] FETCH_RD   = 2'b01;

  localparam logic [7:0] HALT_OPCODE_DEF = 8'hFF;
  localparam logic [7:0] START_ADDR_DEF  = 8'h00;

  // One-hot-by-construction PC update requests from the FSM.
  typedef struct packed {
    logic load_start;
    logic load_jump;
    logic inc;
  } pc_ctrl_t;

endpackage

// File: rtl/fetch_pc.sv
// Program counter: reload to START_ADDR, jump redirect, or increment with
// natural 8-bit wrap. Priority is start > jump > increment.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter logic [7:0] START_ADDR = START_ADDR_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  pc_ctrl_t   i_ctrl,
  input  logic [7:0] i_jump_addr,
  output logic [7:0] o_pc
);

  logic [7:0] r_pc;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= START_ADDR;
    end else if (i_ctrl.load_start) begin
      r_pc <= START_ADDR;
    end else if (i_ctrl.load_jump) begin
      r_pc <= i_jump_addr;
    end else if (i_ctrl.inc) begin
      r_pc <= r_pc + 8'd1;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: issues a read, captures the registered data,
// and hands it to the decoder over valid/ready. Jump redirect is compiled in
// only when FETCH_JUMP_EN is defined.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [7:0] HALT_OPCODE = HALT_OPCODE_DEF,
  parameter logic [7:0] START_ADDR  = START_ADDR_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [7:0] iAddr,
  output logic [1:0] FETCH,
  input  logic [7:0] instr,
  output logic [7:0] ir,
  output logic       ir_valid,
  input  logic       ir_ready,
  input  logic       jump_req,
  input  logic [7:0] jump_addr,
  input  logic       halt_req,
  output logic       busy,
  output logic       halted
);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_ir;
  logic [7:0] w_pc;
  pc_ctrl_t   w_pc_ctrl;
  logic       w_ir_load;
  logic [1:0] w_fetch;
  logic       w_handshake;
  logic       w_halt_now;
  logic       w_jump_req;
  logic [7:0] w_jump_addr;

`ifdef FETCH_JUMP_EN
  assign w_jump_req  = jump_req;
  assign w_jump_addr = jump_addr;
`else
  // Ports stay on the boundary so both builds share one pinout.
  logic w_unused_jump;
  assign w_jump_req    = 1'b0;
  assign w_jump_addr   = 8'h00;
  assign w_unused_jump = ^{jump_req, jump_addr};
`endif

  assign w_handshake = (r_state == HOLD) && ir_ready;
  assign w_halt_now  = (r_ir == HALT_OPCODE) || halt_req;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next    = r_state;
    w_fetch   = FETCH_IDLE;
    w_ir_load = 1'b0;
    w_pc_ctrl = '0;
    case (r_state)
      IDLE, HALTED: begin
        if (start) begin
          w_pc_ctrl.load_start = 1'b1;
          w_next               = ISSUE;
        end
      end
      ISSUE: begin
        w_fetch = FETCH_RD;
        w_next  = WAIT;
      end
      WAIT: begin
        w_ir_load     = 1'b1;
        w_pc_ctrl.inc = 1'b1;
        w_next        = HOLD;
      end
      HOLD: begin
        if (w_handshake) begin
          // Jump still loads the PC when the same handshake also halts.
          w_pc_ctrl.load_jump = w_jump_req;
          w_next              = w_halt_now ? HALTED : ISSUE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ir only changes in WAIT, so it is stable for the whole HOLD window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir <= 8'h00;
    end else if (w_ir_load) begin
      r_ir <= instr;
    end
  end

  fetch_pc #(
    .START_ADDR (START_ADDR)
  ) u_pc (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_ctrl      (w_pc_ctrl),
    .i_jump_addr (w_jump_addr),
    .o_pc        (w_pc)
  );

  assign iAddr    = w_pc;
  assign FETCH    = w_fetch;
  assign ir       = r_ir;
  assign ir_valid = (r_state == HOLD);
  assign busy     = (r_state == ISSUE) || (r_state == WAIT) || (r_state == HOLD);
  assign halted   = (r_state == HALTED);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a transaction-level model tracks the PC
// and halt status per instruction; expectations follow FETCH_JUMP_EN.
module tb_fetch_ctrl;

  localparam logic [7:0] HALT  = 8'hFF;
  localparam logic [7:0] START = 8'h00;
`ifdef FETCH_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] iAddr;
  logic [1:0] FETCH;
  logic [7:0] instr;
  logic [7:0] ir;
  logic       ir_valid;
  logic       ir_ready;
  logic       jump_req;
  logic [7:0] jump_addr;
  logic       halt_req;
  logic       busy;
  logic       halted;

  logic [7:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_pc;
  bit         m_halted;

  fetch_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .iAddr     (iAddr),
    .FETCH     (FETCH),
    .instr     (instr),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .jump_req  (jump_req),
    .jump_addr (jump_addr),
    .halt_req  (halt_req),
    .busy      (busy),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory: data appears the cycle after the read.
  always @(posedge clk) begin
    if (FETCH == 2'b01) instr <= mem[iAddr];
  end

  // Called at a negedge while idle or halted; optionally idles with noise first.
  task automatic do_start(input bit noise);
    if (noise) begin
      for (int i = 0; i < 2; i++) begin
        jump_req  = 1'($urandom);
        halt_req  = 1'($urandom);
        jump_addr = 8'($urandom);
        @(negedge clk);
        n_tests++;
        if ({FETCH, busy, ir_valid, halted, iAddr} !== {2'b00, 1'b0, 1'b0, m_halted, m_pc}) begin
          n_fail++;
          $display("FAIL idle_hold: got %h required %h",
                   {FETCH, busy, ir_valid, halted, iAddr}, {2'b00, 1'b0, 1'b0, m_halted, m_pc});
        end
      end
    end
    jump_req = 1'b0;
    halt_req = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    m_pc     = START;
    m_halted = 1'b0;
  endtask

  // One instruction; entered at the ISSUE negedge, leaves at the negedge after handshake.
  task automatic step(input bit jmp, input logic [7:0] ja, input bit hlt,
                      input int stall, input bit noise);
    logic [7:0] exp_ir;
    logic [7:0] inc_pc;
    exp_ir = mem[m_pc];
    inc_pc = m_pc + 8'd1;

    n_tests++;
    if ({FETCH, iAddr, busy, ir_valid, halted} !== {2'b01, m_pc, 3'b100}) begin
      n_fail++;
      $display("FAIL issue: got %h required %h",
               {FETCH, iAddr, busy, ir_valid, halted}, {2'b01, m_pc, 3'b100});
    end
    ir_ready = (stall == 0);
    if (noise) begin
      start = 1'($urandom); jump_req = 1'($urandom);
      halt_req = 1'($urandom); jump_addr = 8'($urandom);
    end
    @(negedge clk);

    n_tests++;
    if ({FETCH, iAddr, busy, ir_valid, halted} !== {2'b00, m_pc, 3'b100}) begin
      n_fail++;
      $display("FAIL wait: got %h required %h",
               {FETCH, iAddr, busy, ir_valid, halted}, {2'b00, m_pc, 3'b100});
    end
    if (noise) begin
      start = 1'($urandom); jump_req = 1'($urandom);
      halt_req = 1'($urandom); jump_addr = 8'($urandom);
    end
    @(negedge clk);
    start = 1'b0;

    n_tests++;
    if ({FETCH, iAddr, busy, ir_valid, halted, ir} !== {2'b00, inc_pc, 3'b110, exp_ir}) begin
      n_fail++;
      $display("FAIL hold: got %h required %h",
               {FETCH, iAddr, busy, ir_valid, halted, ir}, {2'b00, inc_pc, 3'b110, exp_ir});
    end
    for (int i = 0; i < stall; i++) begin
      if (noise) begin
        jump_req = 1'($urandom); halt_req = 1'($urandom); jump_addr = 8'($urandom);
      end
      @(negedge clk);
      n_tests++;
      if ({FETCH, iAddr, busy, ir_valid, halted, ir} !== {2'b00, inc_pc, 3'b110, exp_ir}) begin
        n_fail++;
        $display("FAIL stall: got %h required %h",
                 {FETCH, iAddr, busy, ir_valid, halted, ir}, {2'b00, inc_pc, 3'b110, exp_ir});
      end
    end

    ir_ready  = 1'b1;
    jump_req  = jmp;
    jump_addr = ja;
    halt_req  = hlt;
    @(negedge clk);
    jump_req  = 1'b0;
    halt_req  = 1'b0;

    m_halted = (exp_ir == HALT) || hlt;
    m_pc     = (JUMP_EN && jmp) ? ja : inc_pc;
    if (m_halted) begin
      n_tests++;
      if ({FETCH, iAddr, busy, ir_valid, halted} !== {2'b00, m_pc, 3'b001}) begin
        n_fail++;
        $display("FAIL halt: got %h required %h",
                 {FETCH, iAddr, busy, ir_valid, halted}, {2'b00, m_pc, 3'b001});
      end
    end
  endtask

  task automatic load_program();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 5; i++) mem[i] = 8'(i + 1);
    mem[5] = HALT;
  endtask

  task automatic fill_no_halt();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 254));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; ir_ready = 1'b1;
    jump_req = 1'b0; jump_addr = 8'h00; halt_req = 1'b0;
    m_pc = START; m_halted = 1'b0;
    #3;
    n_tests++;
    if ({FETCH, iAddr, ir, busy, ir_valid, halted} !== {2'b00, START, 8'h00, 3'b000}) begin
      n_fail++;
      $display("FAIL reset: got %h required %h",
               {FETCH, iAddr, ir, busy, ir_valid, halted}, {2'b00, START, 8'h00, 3'b000});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({FETCH, busy, halted} !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h required %h", {FETCH, busy, halted}, 4'b0000);
    end
  endtask

  task automatic test_program();
    load_program();
    do_start(1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0, 0, 1'b0);
    n_tests++;
    if ({halted, FETCH} !== 3'b100) begin
      n_fail++;
      $display("FAIL program_end: got %h required %h", {halted, FETCH}, 3'b100);
    end
  endtask

  task automatic test_stall();
    load_program();
    do_start(1'b0);
    step(1'b0, 8'h00, 1'b0, 5, 1'b0);
    step(1'b0, 8'h00, 1'b0, 5, 1'b1);
    step(1'b0, 8'h00, 1'b1, 0, 1'b0);
  endtask

  task automatic test_jump();
    load_program();
    do_start(1'b0);
    step(1'b1, 8'h03, 1'b0, 0, 1'b0);
    n_tests++;
    if (iAddr !== (JUMP_EN ? 8'h03 : 8'h01)) begin
      n_fail++;
      $display("FAIL jump_target: got %h required %h", iAddr, JUMP_EN ? 8'h03 : 8'h01);
    end
    step(1'b0, 8'h00, 1'b0, 0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 0, 1'b0);
  endtask

  task automatic test_wrap();
    fill_no_halt();
    do_start(1'b1);
    for (int i = 0; i < 256; i++) step(1'b0, 8'h00, 1'b0, $urandom_range(0, 1), 1'b1);
    n_tests++;
    if ({FETCH, iAddr} !== {2'b01, 8'h00}) begin
      n_fail++;
      $display("FAIL wrap: got %h required %h", {FETCH, iAddr}, {2'b01, 8'h00});
    end
    step(1'b0, 8'h00, 1'b0, 0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    fill_no_halt();
    do_start(1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({FETCH, iAddr, ir, busy, ir_valid, halted} !== {2'b00, START, 8'h00, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_mid: got %h required %h",
               {FETCH, iAddr, ir, busy, ir_valid, halted}, {2'b00, START, 8'h00, 3'b000});
    end
    @(negedge clk);
    rst_n    = 1'b1;
    m_pc     = START;
    m_halted = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_tests++;
      if ({FETCH, busy, halted} !== 4'b0000) begin
        n_fail++;
        $display("FAIL no_fetch_after_reset: got %h required %h", {FETCH, busy, halted}, 4'b0000);
      end
    end
    do_start(1'b0);
    step(1'b0, 8'h00, 1'b1, 0, 1'b0);
  endtask

  task automatic test_halt_jump();
    logic [7:0] ja;
    fill_no_halt();
    ja = 8'($urandom_range(8, 200));
    do_start(1'b0);
    step(1'b1, ja, 1'b1, 0, 1'b0);
    n_tests++;
    if ({halted, iAddr} !== {1'b1, JUMP_EN ? ja : 8'h01}) begin
      n_fail++;
      $display("FAIL halt_jump: got %h required %h", {halted, iAddr}, {1'b1, JUMP_EN ? ja : 8'h01});
    end
    do_start(1'b1);
    step(1'b0, 8'h00, 1'b1, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 11) == 0) ? HALT : 8'($urandom_range(0, 254));
    for (int n = 0; n < 80; n++) begin
      if (m_halted) do_start(1'($urandom));
      step($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 3), 1'b1);
    end
    if (!m_halted) step(1'b0, 8'h00, 1'b1, 0, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_program();
    test_stall();
    test_jump();
    test_wrap();
    test_reset_mid();
    test_halt_jump();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter HALT_OPCODE, default 8'hFF; opcode that stops sequencing once handed off.
REQ-002 Parameter START_ADDR, default 8'h00; PC value loaded on reset and on start.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  begins sequencing from START_ADDR when in IDLE or HALTED.
REQ-006 iAddr  out  8  instruction memory address, equals PC.
REQ-007 FETCH  out  2  memory control: 2'b01 read, 2'b00 idle.
REQ-008 instr  in  8  registered memory read data.
REQ-009 ir  out  8  instruction register presented to decoder.
REQ-010 ir_valid / ir_ready  out / in  1 / 1  valid-ready handshake to decoder.
REQ-011 jump_req, jump_addr  in  1, 8  PC redirect, sampled only at handshake.
REQ-012 halt_req  in  1  external stop request, sampled only at handshake.
REQ-013 busy, halted  out  1, 1  state flags.

Function
REQ-014 The FSM SHALL have the states IDLE, ISSUE, WAIT, HOLD and HALTED.
REQ-015 IDLE/HALTED: on start=1, PC<=START_ADDR and the FSM goes to ISSUE; otherwise it stays.
REQ-016 ISSUE: FETCH=2'b01 and iAddr=PC, driven from state; the FSM goes unconditionally to WAIT.
REQ-017 In every state except ISSUE, FETCH=2'b00.
REQ-018 WAIT: at the clock edge, ir<=instr and PC<=PC+1 (8-bit, 8'hFF wraps to 8'h00); the FSM goes to HOLD.
REQ-019 HOLD: ir_valid=1; ir stays stable until the handshake (ir_valid&&ir_ready at a posedge).
REQ-020 On handshake with jump_req=1, PC<=jump_addr, overriding the incremented PC.
REQ-021 On handshake, the next state is HALTED if ir==HALT_OPCODE or halt_req=1; otherwise it is ISSUE.
REQ-022 If halt and jump occur together, HALTED SHALL win and PC SHALL still load jump_addr.
REQ-023 ir_valid SHALL be 0 outside HOLD; busy=1 in ISSUE, WAIT and HOLD; halted=1 only in HALTED.
REQ-024 Latency: start sampled at edge k gives ISSUE in cycle k+1 and ir_valid in cycle k+3; steady-state throughput is 1 instruction per 3 cycles with ir_ready held at 1.
REQ-025 start SHALL be ignored in ISSUE, WAIT and HOLD; jump_req and halt_req SHALL be ignored outside the handshake.

Reset
REQ-026 While rst_n=0 (asynchronous): state=IDLE, PC=START_ADDR, ir=8'h00, FETCH=2'b00, ir_valid=0, busy=0, halted=0.
REQ-027 Reset mid-fetch SHALL abandon the fetch in progress; the first post-reset fetch occurs only after start.

Configuration
REQ-028 Macro FETCH_JUMP_EN: when defined, REQ-011, REQ-020 and REQ-022 apply.
REQ-029 When FETCH_JUMP_EN is undefined, jump_req and jump_addr SHALL be ignored and the PC only increments or reloads on start; the ports remain present.

Structure
REQ-030 Package fetch_pkg SHALL hold the FSM state enum, the FETCH codes FETCH_IDLE=2'b00 and FETCH_RD=2'b01, and the default HALT_OPCODE.
REQ-031 One sub-module, fetch_pc, SHALL hold the PC register with load, increment/wrap and jump muxing; the FSM SHALL live in fetch_ctrl.

Verification
REQ-032 The bench SHALL cover: memory holds 01,02,03,04,05,FF at 0..5, ir_ready=1, start pulse -> ir sequence 01..05,FF, one handshake every 3 cycles, then halted=1 and FETCH=00.
REQ-033 The bench SHALL cover: ir_ready held 0 for 5 cycles in HOLD -> ir and ir_valid stable, FETCH=00 throughout, PC unchanged.
REQ-034 The bench SHALL cover: FETCH_JUMP_EN defined, jump_req=1 with jump_addr=8'h03 at the first handshake -> the next ISSUE drives iAddr=03 and ir=04.
REQ-035 The bench SHALL cover: PC=8'hFF, fetch completes -> PC wraps to 8'h00 and the next iAddr=00.
REQ-036 The bench SHALL cover: rst_n pulsed low during WAIT -> all outputs at reset values immediately; no further FETCH=01 until start.
REQ-037 The bench SHALL cover: halt_req=1 and jump_req=1 at the same handshake -> HALTED, PC=jump_addr, and restart via start begins at START_ADDR.
